shift_arbiter: RTL and testbench

SHIFT_ARBITER -- requirements
Module: shift_arbiter

---
 rtl/shift_arbiter_pkg.sv | 16 +
 rtl/rr_arb2.sv | 16 +
 rtl/shift_arbiter.sv | 115 +++++++++++
 tb/tb_shift_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the two-requester shift arbiter: widths, requester ids
// and the response register state encoding.
package shift_arbiter_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes to the
// requester named by prio_i.
module rr_arb2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = req_i;
        if (req_i == 2'b11) begin
            gnt_o = prio_i ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two shift requesters onto one external combinational shifter and
// holds the result in a one-entry response register.
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter logic PRIO_INIT = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               r0_valid,
    input  logic               r1_valid,
    output logic               r0_ready,
    output logic               r1_ready,
    input  logic [XLEN-1:0]    r0_data,
    input  logic [XLEN-1:0]    r1_data,
    input  logic [SHAMT_W-1:0] r0_amt,
    input  logic [SHAMT_W-1:0] r1_amt,
    input  logic               r0_right,
    input  logic               r1_right,
    input  logic               r0_sra,
    input  logic               r1_sra,
    output logic [XLEN-1:0]    sh_datain,
    output logic [SHAMT_W-1:0] sh_amt,
    output logic               sh_right,
    output logic               sh_sra,
    input  logic [XLEN-1:0]    sh_dataout,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [XLEN-1:0]    rsp_data,
    output logic               rsp_id,
    output rsp_state_e         dbg_state,
    output logic               dbg_prio
);

    rsp_state_e      state_q, state_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;
    logic            rsp_id_q, rsp_id_d;
    logic            prio_q, prio_d;

    logic [1:0] gnt;
    logic       win_valid;
    logic       win_id;
    logic       accept_ok;
    logic       hs;

    rr_arb2 u_rr_arb2 (
        .req_i  ({r1_valid, r0_valid}),
        .prio_i (prio_q),
        .gnt_o  (gnt)
    );

    assign win_valid = |gnt;
    assign win_id    = gnt[1];
    // rst gates the handshake so no request is consumed while reset is held.
    assign accept_ok = ((state_q == ST_EMPTY) || rsp_ready) && !rst;
    assign hs        = win_valid && accept_ok;
    assign r0_ready  = gnt[0] && accept_ok;
    assign r1_ready  = gnt[1] && accept_ok;

    always_comb begin
        sh_datain = '0;
        sh_amt    = '0;
        sh_right  = 1'b0;
        sh_sra    = 1'b0;
        if (win_valid) begin
            if (win_id == REQ_LSU) begin
                sh_datain = r1_data;
                sh_amt    = r1_amt;
                sh_right  = r1_right;
                sh_sra    = r1_sra && r1_right;
            end else begin
                sh_datain = r0_data;
                sh_amt    = r0_amt;
                sh_right  = r0_right;
                sh_sra    = r0_sra && r0_right;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = rsp_data_q;
        rsp_id_d   = rsp_id_q;
        prio_d     = prio_q;
        if (hs) begin
            state_d    = ST_FULL;
            rsp_data_d = sh_dataout;
            rsp_id_d   = win_id;
            prio_d     = ~win_id;
        end else if (state_q == ST_FULL && rsp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            rsp_data_q <= '0;
            rsp_id_q   <= 1'b0;
            prio_q     <= PRIO_INIT;
        end else begin
            state_q    <= state_d;
            rsp_data_q <= rsp_data_d;
            rsp_id_q   <= rsp_id_d;
            prio_q     <= prio_d;
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign dbg_state = state_q;
    assign dbg_prio  = prio_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter with a behavioural 32-bit shifter wired to
// the sh_* port group.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               r0_valid = 1'b0, r1_valid = 1'b0;
    logic               r0_ready, r1_ready;
    logic [XLEN-1:0]    r0_data = '0, r1_data = '0;
    logic [SHAMT_W-1:0] r0_amt = '0, r1_amt = '0;
    logic               r0_right = 1'b0, r1_right = 1'b0;
    logic               r0_sra = 1'b0, r1_sra = 1'b0;
    logic [XLEN-1:0]    sh_datain;
    logic [SHAMT_W-1:0] sh_amt;
    logic               sh_right, sh_sra;
    logic [XLEN-1:0]    sh_dataout;
    logic               rsp_valid;
    logic               rsp_ready = 1'b0;
    logic [XLEN-1:0]    rsp_data;
    logic               rsp_id;
    rsp_state_e         dbg_state;
    logic               dbg_prio;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    always_comb begin
        if (!sh_right)
            sh_dataout = sh_datain << sh_amt;
        else if (sh_sra)
            sh_dataout = $unsigned($signed(sh_datain) >>> sh_amt);
        else
            sh_dataout = sh_datain >> sh_amt;
    end

    shift_arbiter #(.PRIO_INIT(1'b0)) dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r1_valid(r1_valid),
        .r0_ready(r0_ready), .r1_ready(r1_ready),
        .r0_data(r0_data), .r1_data(r1_data),
        .r0_amt(r0_amt), .r1_amt(r1_amt),
        .r0_right(r0_right), .r1_right(r1_right),
        .r0_sra(r0_sra), .r1_sra(r1_sra),
        .sh_datain(sh_datain), .sh_amt(sh_amt),
        .sh_right(sh_right), .sh_sra(sh_sra),
        .sh_dataout(sh_dataout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .dbg_state(dbg_state), .dbg_prio(dbg_prio)
    );

    task automatic set_r0(input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic rt, input logic sa);
        r0_valid = v; r0_data = d; r0_amt = a; r0_right = rt; r0_sra = sa;
    endtask

    task automatic set_r1(input logic v, input logic [31:0] d, input logic [4:0] a,
                          input logic rt, input logic sa);
        r1_valid = v; r1_data = d; r1_amt = a; r1_right = rt; r1_sra = sa;
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%h id=%b, want 0/00000000/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        n_tests++;
        if (dbg_prio !== 1'b0 || dbg_state !== ST_EMPTY) begin
            n_fail++;
            $display("FAIL reset_state: prio=%b state=%b, want 0/0", dbg_prio, dbg_state);
        end
        n_tests++;
        if (sh_datain !== 32'h0 || sh_amt !== 5'h0 || sh_right !== 1'b0 || sh_sra !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_sh_zero: datain=%h amt=%0d right=%b sra=%b, want all 0",
                     sh_datain, sh_amt, sh_right, sh_sra);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
    endtask

    task automatic test_single_r0;
        @(negedge clk);
        set_r0(1'b1, 32'hFFFF_FFFF, 5'd4, 1'b1, 1'b0);
        #1;
        n_tests++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_only_ready: r0_ready=%b r1_ready=%b, want 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0FFF_FFFF || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL r0_srl: valid=%b data=%h id=%b, want 1/0fffffff/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        set_r0(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0FFF_FFFF || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_hold: valid=%b data=%h id=%b, want 0/0fffffff/0",
                     rsp_valid, rsp_data, rsp_id);
        end
    endtask

    task automatic test_single_r1;
        @(negedge clk);
        set_r1(1'b1, 32'h8000_0000, 5'd31, 1'b1, 1'b1);
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'hFFFF_FFFF || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL r1_sra: valid=%b data=%h id=%b, want 1/ffffffff/1",
                     rsp_valid, rsp_data, rsp_id);
        end
        @(negedge clk);
        set_r1(1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b1);
        #1;
        n_tests++;
        if (sh_sra !== 1'b0 || sh_right !== 1'b0) begin
            n_fail++;
            $display("FAIL left_sra_mask: sh_sra=%b sh_right=%b, want 0/0", sh_sra, sh_right);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_data !== 32'h8000_0000 || rsp_id !== 1'b1) begin
            n_fail++;
            $display("FAIL r1_sll: data=%h id=%b, want 80000000/1", rsp_data, rsp_id);
        end
        @(negedge clk);
        set_r1(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_round_robin;
        logic [31:0] exp_d;
        set_r0(1'b1, 32'h0000_0011, 5'd1, 1'b0, 1'b0);
        set_r1(1'b1, 32'h0000_0100, 5'd4, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp_d = (i % 2 == 0) ? 32'h0000_0022 : 32'h0000_0010;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_id !== 1'(i % 2) || rsp_data !== exp_d) begin
                n_fail++;
                $display("FAIL rr_cycle%0d: valid=%b id=%b data=%h, want 1/%0d/%h",
                         i, rsp_valid, rsp_id, rsp_data, i % 2, exp_d);
            end
        end
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_ready%0d: r0_ready=%b r1_ready=%b, want 0/0",
                         i, r0_ready, r1_ready);
            end
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_0010 || rsp_id !== 1'b1) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h id=%b, want 1/00000010/1",
                         i, rsp_valid, rsp_data, rsp_id);
            end
            @(negedge clk);
        end
        set_r0(1'b1, 32'h0000_0033, 5'd2, 1'b0, 1'b0);
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_ready: r0_ready=%b r1_ready=%b, want 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_00CC || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL refill_data: valid=%b data=%h id=%b, want 1/000000cc/0",
                     rsp_valid, rsp_data, rsp_id);
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'h0 || rsp_id !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%b data=%h id=%b, want 0/00000000/0",
                     rsp_valid, rsp_data, rsp_id);
        end
        n_tests++;
        if (dbg_prio !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_prio_ready: prio=%b r0_ready=%b r1_ready=%b, want 0/0/0",
                     dbg_prio, r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || r0_ready !== 1'b0 || r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held: valid=%b r0_ready=%b r1_ready=%b, want 0/0/0",
                     rsp_valid, r0_ready, r1_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #1;
        n_tests++;
        if (r0_ready !== 1'b1 || r1_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL post_reset_grant: r0_ready=%b r1_ready=%b, want 1/0", r0_ready, r1_ready);
        end
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_data !== 32'h0000_00CC) begin
            n_fail++;
            $display("FAIL post_reset_rsp: valid=%b id=%b data=%h, want 1/0/000000cc",
                     rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        set_r1(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic test_amt_zero;
        logic [1:0] mode;
        for (int i = 0; i < 4; i++) begin
            mode = 2'(i);
            set_r0(1'b1, 32'hA5A5_5A5A, 5'd0, mode[0], mode[1]);
            @(posedge clk); #1;
            n_tests++;
            if (rsp_valid !== 1'b1 || rsp_data !== 32'hA5A5_5A5A || rsp_id !== 1'b0) begin
                n_fail++;
                $display("FAIL amt0_mode%0d: valid=%b data=%h id=%b, want 1/a5a55a5a/0",
                         i, rsp_valid, rsp_data, rsp_id);
            end
            @(negedge clk);
        end
        set_r0(1'b0, 32'h0, 5'd0, 1'b0, 1'b0);
        @(posedge clk); #1;
        n_tests++;
        if (rsp_valid !== 1'b0 || rsp_data !== 32'hA5A5_5A5A) begin
            n_fail++;
            $display("FAIL final_empty: valid=%b data=%h, want 0/a5a55a5a", rsp_valid, rsp_data);
        end
    endtask

    initial begin
        test_reset;
        test_single_r0;
        test_single_r1;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_amt_zero;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
